// File: rtl/ahb_xfer_sequencer.sv
// Command-queued transfer generator driving the user side of the AHB master.
// Define SEQ_BEAT_STATS_EN to add beat counters and a command-overflow sticky flag.
module ahb_xfer_sequencer #(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [1:0]        cmd_offset,
   input  logic [3:0]        cmd_len,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [DATA_W-1:0] wd_data,
   input  logic              hready_in,
   input  logic [DATA_W-1:0] hrdata_in,
   output logic              start,
   output logic              burst,
   output logic              data_ready,
   output logic              hwrite_out,
   output logic [ADDR_W-1:0] haddr_out,
   output logic [DATA_W-1:0] hwdata_out,
   output logic [2:0]        hsize_out,
   output logic [1:0]        offset_out,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
`ifdef SEQ_BEAT_STATS_EN
   output logic [15:0]       wr_beats,
   output logic [15:0]       rd_beats,
   output logic              err_sticky,
`endif
   output logic              busy
);

   localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned EntW = ADDR_W + 10;
   localparam logic [PtrW:0] PtrOne = 1;

   typedef enum logic [2:0] {StIdle, StLoad, StNseq, StSeq, StWaitd, StDone} state_e;

   state_e state_q, state_d;

   logic [EntW-1:0]   fifo_q [CMD_DEPTH];
   logic [PtrW:0]     wptr_q, rptr_q;
   logic              full, empty, push, pop;

   logic              h_write;
   logic [ADDR_W-1:0] h_addr;
   logic [2:0]        h_size;
   logic [1:0]        h_offset;
   logic [3:0]        h_len;

   logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
   logic [2:0]        size_q, size_d;
   logic [1:0]        offset_q, offset_d;
   logic              write_q, write_d;
   logic [3:0]        remain_q, remain_d;
   logic              first_q, first_d;
   logic              split_q, split_d;
   logic              rd_pend_q, rd_pend_d;
   logic              accept, active, beat_st;

   // Extra pointer bit distinguishes full from empty.
   assign full      = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
   assign empty     = (wptr_q == rptr_q);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state_q == StLoad);

   assign {h_write, h_addr, h_size, h_offset, h_len} = fifo_q[rptr_q[PtrW-1:0]];

   always_ff @(posedge hclk) begin
      if (push) begin
         fifo_q[wptr_q[PtrW-1:0]] <= {cmd_write, cmd_addr, cmd_size, cmd_offset, cmd_len};
      end
   end

   assign addr_nxt = addr_q + (ADDR_W'(1) << size_q);
   assign accept   = data_ready && hready_in;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      offset_d   = offset_q;
      write_d    = write_q;
      remain_d   = remain_q;
      first_d    = first_q;
      split_d    = split_q;
      start      = 1'b0;
      burst      = 1'b0;
      data_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) state_d = StLoad;
         end
         StLoad: begin
            addr_d   = h_addr;
            size_d   = (h_size > 3'd2) ? 3'd2 : h_size;
            offset_d = h_offset;
            write_d  = h_write;
            remain_d = h_len;
            first_d  = 1'b1;
            split_d  = 1'b0;
            state_d  = StNseq;
         end
         StNseq, StSeq: begin
            start      = 1'b1;
            burst      = (state_q == StSeq) || (remain_q != 4'd0);
            data_ready = write_q ? wd_valid : 1'b1;
            if (write_q && !wd_valid) begin
               first_d = (state_q == StNseq);
               state_d = StWaitd;
            end else if (accept) begin
               if (remain_q == 4'd0) begin
                  state_d = StDone;
               end else begin
                  addr_d   = addr_nxt;
                  remain_d = remain_q - 4'd1;
                  // Crossing a 1KB page ends this burst; DONE restarts it as a fresh NSEQ.
                  if (addr_nxt[10] != addr_q[10]) begin
                     split_d = 1'b1;
                     state_d = StDone;
                  end else begin
                     state_d = StSeq;
                  end
               end
            end
         end
         StWaitd: begin
            start = 1'b1;
            burst = first_q ? (remain_q != 4'd0) : 1'b1;
            if (wd_valid) state_d = first_q ? StNseq : StSeq;
         end
         StDone: begin
            if (split_q) begin
               split_d = 1'b0;
               first_d = 1'b1;
               state_d = StNseq;
            end else if (!empty) begin
               state_d = StLoad;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_pend_d = rd_pend_q;
      if (accept && !write_q) begin
         rd_pend_d = 1'b1;
      end else if (rd_pend_q && hready_in) begin
         rd_pend_d = 1'b0;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q   <= StIdle;
         wptr_q    <= '0;
         rptr_q    <= '0;
         addr_q    <= '0;
         size_q    <= 3'd0;
         offset_q  <= 2'd0;
         write_q   <= 1'b0;
         remain_q  <= 4'd0;
         first_q   <= 1'b0;
         split_q   <= 1'b0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         offset_q  <= offset_d;
         write_q   <= write_d;
         remain_q  <= remain_d;
         first_q   <= first_d;
         split_q   <= split_d;
         rd_pend_q <= rd_pend_d;
         if (push) wptr_q <= wptr_q + PtrOne;
         if (pop)  rptr_q <= rptr_q + PtrOne;
      end
   end

   assign active     = (state_q != StIdle);
   assign beat_st    = (state_q == StNseq) || (state_q == StSeq);
   assign hwrite_out = active && write_q;
   assign haddr_out  = active ? addr_q : '0;
   assign hsize_out  = active ? size_q : 3'd0;
   assign offset_out = active ? offset_q : 2'd0;
   assign hwdata_out = beat_st ? wd_data : '0;
   assign wd_ready   = wd_valid && accept && write_q;
   // Read data is taken in the cycle after acceptance, stretched over wait states.
   assign rd_valid   = rd_pend_q && hready_in;
   assign rd_data    = rd_valid ? hrdata_in : '0;
   assign busy       = active || !empty;

`ifdef SEQ_BEAT_STATS_EN
   logic [15:0] wr_beats_q, rd_beats_q;
   logic        err_sticky_q;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         wr_beats_q   <= 16'd0;
         rd_beats_q   <= 16'd0;
         err_sticky_q <= 1'b0;
      end else begin
         if (accept && write_q && (wr_beats_q != 16'hFFFF)) wr_beats_q <= wr_beats_q + 16'd1;
         if (accept && !write_q && (rd_beats_q != 16'hFFFF)) rd_beats_q <= rd_beats_q + 16'd1;
         if (cmd_valid && !cmd_ready) err_sticky_q <= 1'b1;
      end
   end

   assign wr_beats   = wr_beats_q;
   assign rd_beats   = rd_beats_q;
   assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_ahb_xfer_sequencer.sv
// Directed and randomized bench for ahb_xfer_sequencer against a beat-list reference model.
module tb_ahb_xfer_sequencer;

   logic        hclk       = 1'b0;
   logic        hreset     = 1'b1;
   logic        cmd_valid  = 1'b0;
   logic        cmd_ready;
   logic        cmd_write  = 1'b0;
   logic [31:0] cmd_addr   = '0;
   logic [2:0]  cmd_size   = '0;
   logic [1:0]  cmd_offset = '0;
   logic [3:0]  cmd_len    = '0;
   logic        wd_valid   = 1'b0;
   logic        wd_ready;
   logic [31:0] wd_data    = '0;
   logic        hready_in  = 1'b1;
   logic [31:0] hrdata_in  = '0;
   logic        start, burst, data_ready, hwrite_out;
   logic [31:0] haddr_out, hwdata_out;
   logic [2:0]  hsize_out;
   logic [1:0]  offset_out;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        busy;
`ifdef SEQ_BEAT_STATS_EN
   logic [15:0] wr_beats, rd_beats;
   logic        err_sticky;
`endif

   ahb_xfer_sequencer #(.CMD_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .hclk       (hclk),
      .hreset     (hreset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_size   (cmd_size),
      .cmd_offset (cmd_offset),
      .cmd_len    (cmd_len),
      .wd_valid   (wd_valid),
      .wd_ready   (wd_ready),
      .wd_data    (wd_data),
      .hready_in  (hready_in),
      .hrdata_in  (hrdata_in),
      .start      (start),
      .burst      (burst),
      .data_ready (data_ready),
      .hwrite_out (hwrite_out),
      .haddr_out  (haddr_out),
      .hwdata_out (hwdata_out),
      .hsize_out  (hsize_out),
      .offset_out (offset_out),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
`ifdef SEQ_BEAT_STATS_EN
      .wr_beats   (wr_beats),
      .rd_beats   (rd_beats),
      .err_sticky (err_sticky),
`endif
      .busy       (busy)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  off;
      logic        burst;
      logic        seg_end;
   } beat_t;

   beat_t exp_q[$];
   int    n_pass = 0, n_fail = 0, n_total = 0;
   int    n_acc = 0, n_wdr = 0, n_rdv = 0, n_wr_acc = 0, n_rd_acc = 0;
   bit    rd_pend = 0, gap_exp = 0, pushed = 0, ovf_seen = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // A command expands to its list of beat addresses; a 1KB crossing starts a new segment.
   function automatic void add_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                                   input logic [1:0] off, input logic [3:0] len);
      int          n   = int'(len) + 1;
      logic [2:0]  esz = (sz > 3'd2) ? 3'd2 : sz;
      logic [31:0] inc = 32'd1 << esz;
      for (int i = 0; i < n; i++) begin
         beat_t       b;
         logic [31:0] ad, pa, na;
         bit          seg_start;
         ad        = a + inc * i;
         pa        = ad - inc;
         na        = ad + inc;
         seg_start = (i == 0) || (ad[10] != pa[10]);
         b.addr    = ad;
         b.wr      = wr;
         b.size    = esz;
         b.off     = off;
         b.burst   = seg_start ? (i != n - 1) : 1'b1;
         b.seg_end = (i == n - 1) || (na[10] != ad[10]);
         exp_q.push_back(b);
      end
   endfunction

   task automatic cycle();
      beat_t b;
      bit    consumed = 0;
      pushed = 1'b0;
      @(negedge hclk);
      if (hreset) begin
         exp_q.delete();
         rd_pend  = 1'b0;
         gap_exp  = 1'b0;
         ovf_seen = 1'b0;
         n_wr_acc = 0;
         n_rd_acc = 0;
      end else begin
         if (cmd_valid && !cmd_ready) ovf_seen = 1'b1;
         if (cmd_valid && cmd_ready) begin
            add_cmd(cmd_write, cmd_addr, cmd_size, cmd_offset, cmd_len);
            pushed = 1'b1;
         end
         if (gap_exp) begin
            chk("gap_start", start, 0);
            chk("gap_data_ready", data_ready, 0);
            gap_exp = 1'b0;
         end
         if (rd_pend && hready_in) begin
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, hrdata_in);
            rd_pend = 1'b0;
            n_rdv++;
         end else begin
            chk("rd_valid_idle", rd_valid, 0);
         end
         if (data_ready && hready_in) begin
            if (exp_q.size() == 0) begin
               chk("spurious_beat", data_ready, 0);
            end else begin
               b = exp_q.pop_front();
               chk("beat_addr", haddr_out, b.addr);
               chk("beat_write", hwrite_out, b.wr);
               chk("beat_size", hsize_out, b.size);
               chk("beat_offset", offset_out, b.off);
               chk("beat_burst", burst, b.burst);
               chk("beat_start", start, 1);
               if (b.wr) begin
                  chk("beat_hwdata", hwdata_out, wd_data);
                  chk("beat_wd_ready", wd_ready, 1);
                  n_wr_acc++;
               end else begin
                  chk("beat_rd_wd_ready", wd_ready, 0);
                  rd_pend = 1'b1;
                  n_rd_acc++;
               end
               gap_exp = b.seg_end;
               n_acc++;
            end
         end else begin
            chk("wd_ready_idle", wd_ready, 0);
         end
         if (wd_ready) begin
            n_wdr++;
            consumed = 1;
         end
      end
      @(posedge hclk);
      #1;
      hrdata_in = $urandom;
      if (consumed) wd_data = $urandom;
   endtask

   task automatic push(input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [1:0] o, input logic [3:0] l);
      int k = 0;
      cmd_write  = w;
      cmd_addr   = a;
      cmd_size   = s;
      cmd_offset = o;
      cmd_len    = l;
      cmd_valid  = 1'b1;
      do begin
         cycle();
         k++;
      end while (!pushed && k < 50);
      cmd_valid = 1'b0;
      if (!pushed) chk("push_timeout", cmd_ready, 1);
   endtask

   task automatic wait_acc(input string tag, input int target);
      int k = 0;
      while (n_acc < target && k < 100) begin
         cycle();
         k++;
      end
      chk(tag, n_acc, target);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      cmd_valid = 1'b0;
      wd_valid  = 1'b1;
      hready_in = 1'b1;
      while ((exp_q.size() != 0 || gap_exp || rd_pend || busy) && k < 400) begin
         cycle();
         k++;
      end
      chk({tag, "_beats_left"}, exp_q.size(), 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int          w0, r0, base, k, sent;
      logic [31:0] d0, ra;
      bit          have;

      // Reset state
      hreset = 1'b1;
      cycle();
      cycle();
      hreset = 1'b0;
      chk("rst_start", start, 0);
      chk("rst_burst", burst, 0);
      chk("rst_data_ready", data_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_haddr", haddr_out, 0);
      chk("rst_rd_valid", rd_valid, 0);

      // Single write
      wd_valid  = 1'b1;
      wd_data   = 32'h1122_3344;
      hready_in = 1'b1;
      w0 = n_wdr;
      push(1'b1, 32'h0, 3'b010, 2'd0, 4'd0);
      k = 0;
      while (!data_ready && k < 20) begin
         cycle();
         k++;
      end
      chk("single_start", start, 1);
      chk("single_haddr", haddr_out, 32'h0);
      chk("single_hwdata", hwdata_out, 32'h1122_3344);
      chk("single_burst", burst, 0);
      drain("single");
      chk("single_wd_ready", n_wdr - w0, 1);

      // 4-beat read burst at 0x4
      r0 = n_rdv;
      push(1'b0, 32'h4, 3'b010, 2'd0, 4'd3);
      drain("rd4");
      chk("rd4_pulses", n_rdv - r0, 4);

      // Write-data starvation before beat 3
      w0   = n_wdr;
      base = n_acc;
      push(1'b1, 32'h4, 3'b010, 2'd0, 4'd3);
      wait_acc("starve_two_beats", base + 2);
      wd_valid = 1'b0;
      repeat (3) begin
         #1;
         chk("starve_data_ready", data_ready, 0);
         chk("starve_haddr", haddr_out, 32'hC);
         cycle();
      end
      drain("starve");
      chk("starve_wd_ready", n_wdr - w0, 4);

      // Wait states on beat 2 of a burst to 0x2004
      base = n_acc;
      push(1'b1, 32'h2004, 3'b010, 2'd3, 4'd3);
      wait_acc("wait_first_beat", base + 1);
      hready_in = 1'b0;
      d0 = wd_data;
      repeat (5) begin
         #1;
         chk("wait_haddr", haddr_out, 32'h2008);
         chk("wait_hwdata", hwdata_out, d0);
         cycle();
      end
      chk("wait_no_accept", n_acc, base + 1);
      drain("wait");

      // 1KB split followed by a second command (FIFO must pop once per command)
      push(1'b0, 32'h3F8, 3'b010, 2'd1, 4'd3);
      push(1'b1, 32'h500, 3'b000, 2'd2, 4'd0);
      drain("split");

      // Reset mid-burst
      base = n_acc;
      push(1'b1, 32'h100, 3'b010, 2'd0, 4'd7);
      wait_acc("mid_three_beats", base + 3);
      hreset = 1'b1;
      cycle();
      hreset = 1'b0;
      chk("mid_rst_start", start, 0);
      chk("mid_rst_burst", burst, 0);
      chk("mid_rst_data_ready", data_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      w0 = n_wdr;
      repeat (4) cycle();
      chk("mid_rst_no_wd_ready", n_wdr - w0, 0);

      // Randomized traffic
      sent = 0;
      have = 0;
      for (int cyc = 0; cyc < 6000 && (sent < 40 || exp_q.size() != 0 || busy); cyc++) begin
         if (!have && sent < 40) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra | 32'h3E0;
            cmd_write  = $urandom_range(0, 1);
            cmd_addr   = ra;
            cmd_size   = $urandom_range(0, 7);
            cmd_offset = $urandom_range(0, 3);
            cmd_len    = $urandom_range(0, 15);
            have       = 1;
         end
         cmd_valid = have && ($urandom_range(0, 3) != 0);
         wd_valid  = ($urandom_range(0, 9) < 7);
         hready_in = ($urandom_range(0, 9) < 8);
         cycle();
         if (pushed) begin
            have = 0;
            sent++;
         end
      end
      drain("rand");
      chk("rand_cmds_sent", sent, 40);

`ifdef SEQ_BEAT_STATS_EN
      chk("stats_wr_beats", wr_beats, n_wr_acc);
      chk("stats_rd_beats", rd_beats, n_rd_acc);
      chk("stats_err_sticky", err_sticky, ovf_seen);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
